// File: rtl/cache_miss_refill_fsm_if.sv
// rtl/cache_miss_refill_fsm_if.sv - memory-side write/read burst bus of the miss refill controller
`timescale 1ns/1ps
interface cache_miss_refill_fsm_if;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic        mem_wr_ack;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_wlast;
  logic        mem_bvalid;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  modport master (
    output mem_wr_req, mem_wr_addr, mem_wvalid, mem_wdata, mem_wlast,
    output mem_rd_req, mem_rd_addr,
    input  mem_wr_ack, mem_wready, mem_bvalid,
    input  mem_rd_ack, mem_rvalid, mem_rdata, mem_rlast
  );

  modport slave (
    input  mem_wr_req, mem_wr_addr, mem_wvalid, mem_wdata, mem_wlast,
    input  mem_rd_req, mem_rd_addr,
    output mem_wr_ack, mem_wready, mem_bvalid,
    output mem_rd_ack, mem_rvalid, mem_rdata, mem_rlast
  );
endinterface

// File: rtl/cache_miss_refill_fsm.sv
// rtl/cache_miss_refill_fsm.sv - cache miss controller: dirty victim writeback, line refill, install and LRU update
`timescale 1ns/1ps
module cache_miss_refill_fsm #(
  parameter int LINE_WORDS = 16,
  parameter int TAG_W      = 20
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     miss_req,
  input  logic [31:0]              miss_addr,
  input  logic [3:0]               way_sel,
  input  logic                     victim_valid,
  input  logic                     victim_dirty,
  input  logic [TAG_W-1:0]         victim_tag,
  input  logic [32*LINE_WORDS-1:0] victim_line,
  output logic                     busy,
  cache_miss_refill_fsm_if.master  mem,
  output logic                     fill_we,
  output logic [3:0]               fill_way,
  output logic [5:0]               fill_index,
  output logic [TAG_W-1:0]         fill_tag,
  output logic [32*LINE_WORDS-1:0] fill_line,
  output logic                     lru_en,
  output logic [3:0]               lru_visit,
  output logic                     done
);
  localparam logic [3:0] LAST_BEAT = 4'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_DATA, S_WB_RESP, S_RD_REQ, S_RD_DATA, S_FILL, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [3:0]               cnt;
  logic [TAG_W-1:0]         tag_q, vtag_q;
  logic [5:0]               index_q;
  logic [3:0]               way_q;
  logic [32*LINE_WORDS-1:0] vline_q, rbuf;
  logic                     way_onehot;
  logic                     accept;
  logic                     rbeat_last;
  logic                     unused_offset;

  // The byte offset never matters: both bursts are line aligned.
  assign unused_offset = ^miss_addr[5:0];
  assign way_onehot    = (way_sel != 4'd0) && ((way_sel & (way_sel - 4'd1)) == 4'd0);
  assign accept        = (state == S_IDLE) && miss_req;
  assign rbeat_last    = mem.mem_rlast || (cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (miss_req) state_nxt = (victim_valid && victim_dirty) ? S_WB_REQ : S_RD_REQ;
      S_WB_REQ:  if (mem.mem_wr_ack) state_nxt = S_WB_DATA;
      S_WB_DATA: if (mem.mem_wready && (cnt == LAST_BEAT)) state_nxt = S_WB_RESP;
      S_WB_RESP: if (mem.mem_bvalid) state_nxt = S_RD_REQ;
      S_RD_REQ:  if (mem.mem_rd_ack) state_nxt = S_RD_DATA;
      S_RD_DATA: if (mem.mem_rvalid && rbeat_last) state_nxt = S_FILL;
      S_FILL:    state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
      vline_q <= '0;
      rbuf    <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          tag_q   <= miss_addr[31:32-TAG_W];
          index_q <= miss_addr[11:6];
          vtag_q  <= victim_tag;
          way_q   <= way_onehot ? way_sel : 4'b0001;
          vline_q <= victim_line;
          // Cleared so an early rlast leaves the untouched words zero.
          rbuf    <= '0;
          cnt     <= '0;
        end
        S_WB_REQ: cnt <= '0;
        S_WB_DATA: if (mem.mem_wready) cnt <= (cnt == LAST_BEAT) ? 4'd0 : cnt + 4'd1;
        S_RD_REQ: cnt <= '0;
        S_RD_DATA: if (mem.mem_rvalid) begin
          rbuf[{cnt, 5'b0} +: 32] <= mem.mem_rdata;
          cnt                     <= rbeat_last ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (state != S_IDLE);
    mem.mem_wr_req  = 1'b0;
    mem.mem_wr_addr = '0;
    mem.mem_wvalid  = 1'b0;
    mem.mem_wdata   = '0;
    mem.mem_wlast   = 1'b0;
    mem.mem_rd_req  = 1'b0;
    mem.mem_rd_addr = '0;
    fill_we         = 1'b0;
    fill_way        = '0;
    fill_index      = '0;
    fill_tag        = '0;
    fill_line       = '0;
    lru_en          = 1'b0;
    lru_visit       = '0;
    done            = 1'b0;
    case (state)
      S_WB_REQ: begin
        mem.mem_wr_req  = 1'b1;
        mem.mem_wr_addr = {vtag_q, index_q, 6'b0};
      end
      S_WB_DATA: begin
        mem.mem_wvalid = 1'b1;
        mem.mem_wdata  = vline_q[{cnt, 5'b0} +: 32];
        mem.mem_wlast  = (cnt == LAST_BEAT);
      end
      S_RD_REQ: begin
        mem.mem_rd_req  = 1'b1;
        mem.mem_rd_addr = {tag_q, index_q, 6'b0};
      end
      S_FILL: begin
        fill_we    = 1'b1;
        fill_way   = way_q;
        fill_index = index_q;
        fill_tag   = tag_q;
        fill_line  = rbuf;
        lru_en     = 1'b1;
        lru_visit  = way_q;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end
endmodule
